// File: rtl/spi_arb2_if.sv
// spi_arb2_if: client request/ack bus plus SPI-master command/done bus for spi_arb2.
interface spi_arb2_if;
    logic        req0, req1, ack0, ack1, err, busy, spi_wrt, spi_done;
    logic [15:0] cmd0, cmd1, rd_data, spi_cmd, spi_rd_data;
    modport slave (
        input  req0, cmd0, req1, cmd1, spi_done, spi_rd_data,
        output ack0, ack1, rd_data, err, busy, spi_wrt, spi_cmd
    );
    modport master (
        output req0, cmd0, req1, cmd1, spi_done, spi_rd_data,
        input  ack0, ack1, rd_data, err, busy, spi_wrt, spi_cmd
    );
endinterface

// File: rtl/spi_arb2.sv
// spi_arb2: round-robin arbiter/sequencer sharing one SPI master between two clients,
// with done-edge completion, watchdog abort and an idle gap between transactions.
module spi_arb2 #(
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 1024
) (
    input logic       clk,
    input logic       rst_n,
    spi_arb2_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYC == 0) ? 1 : $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          gid_q, gid_d, last_q, last_d, done_q;
    logic          ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
    logic          wrt_q, wrt_d, busy_q, busy_d;
    logic [15:0]   rd_q, rd_d, cmd_q, cmd_d;
    logic          rise, tmo;

    // done is sticky in the master, so only its rising edge marks completion
    assign rise = bus.spi_done & ~done_q;
    assign tmo  = tcnt_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        gid_d   = gid_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        wrt_d   = 1'b0;
        rd_d    = rd_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: if (bus.req0 | bus.req1) begin
                gid_d   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
                cmd_d   = gid_d ? bus.cmd1 : bus.cmd0;
                wrt_d   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: if (rise | tmo) begin
                rd_d    = rise ? bus.spi_rd_data : 16'h0000;
                ack0_d  = ~gid_q;
                ack1_d  = gid_q;
                err_d   = ~rise;
                last_d  = gid_q;
                gcnt_d  = '0;
                state_d = (GAP_CYC == 0) ? IDLE : GAP;
            end else begin
                tcnt_d  = tcnt_q + 1'b1;
            end
            GAP: if (gcnt_q == GW'(GAP_CYC - 1)) state_d = IDLE;
                 else gcnt_d = gcnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            wrt_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 16'h0000;
            cmd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            done_q  <= bus.spi_done;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            wrt_q   <= wrt_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.spi_wrt = wrt_q;
    assign bus.spi_cmd = cmd_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_spi_arb2.sv
// tb_spi_arb2: two arbiters (GAP_CYC 8 and 0) against a cycle-timestamp reference model,
// with directed scenarios plus randomized clients and master latencies.
module tb_spi_arb2;
    localparam int TMO = 1024;

    typedef struct {int c; logic [15:0] d;} wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    bit   rnd_en = 1'b0;

    logic        req0_t [2], req1_t [2];
    logic [15:0] cmd0_t [2], cmd1_t [2];
    int          xfer_t [2];
    bit          hang_t [2];

    logic        ack0_w [2], ack1_w [2], err_w [2], busy_w [2], wrt_w [2];
    logic [15:0] rd_w [2], scmd_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bad(string n, logic [31:0] a, logic [31:0] e);
        if (a !== e) $display("FAIL %s @%0d: got %0h expected %0h", n, cyc, a, e);
        return (a !== e) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GAP = (g == 0) ? 8 : 0;
        spi_arb2_if bus();
        spi_arb2 #(.GAP_CYC(GAP), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

        logic        sd = 1'b0;
        logic [15:0] srd = 16'h0;
        assign bus.req0 = req0_t[g];
        assign bus.req1 = req1_t[g];
        assign bus.cmd0 = cmd0_t[g];
        assign bus.cmd1 = cmd1_t[g];
        assign bus.spi_done = sd;
        assign bus.spi_rd_data = srd;
        assign ack0_w[g] = bus.ack0;
        assign ack1_w[g] = bus.ack1;
        assign err_w[g]  = bus.err;
        assign busy_w[g] = bus.busy;
        assign wrt_w[g]  = bus.spi_wrt;
        assign rd_w[g]   = bus.rd_data;
        assign scmd_w[g] = bus.spi_cmd;

        // SPI master stand-in: drops done one cycle after wrt, raises it m_x cycles after wrt
        int          rise = -1, m_cnt = -1, m_x = 0;
        bit          m_h = 1'b0;
        logic [15:0] m_w = 16'h0;
        always @(negedge clk) begin
            if (bus.spi_wrt) begin
                m_cnt = 0;
                m_x = rnd_en ? int'($urandom_range(3, 60)) : xfer_t[g];
                m_h = rnd_en ? ($urandom_range(0, 15) == 0) : hang_t[g];
                m_w = bus.spi_cmd ^ (rnd_en ? 16'($urandom) : 16'h0);
            end else if (m_cnt >= 0) begin
                m_cnt++;
                if (m_cnt == 1) sd = 1'b0;
                if (m_cnt == m_x && !m_h) begin
                    sd = 1'b1;
                    srd = m_w;
                    rise = cyc;
                    m_cnt = -1;
                end
            end
        end

        // reference model: transactions tracked as issue cycle / earliest-free cycle
        int unsigned mc = 0, iss = 0, free = 0;
        bit          txn = 1'b0, last = 1'b1, id = 1'b0, pd = 1'b0, r;
        logic        e_a0 = 0, e_a1 = 0, e_er = 0, e_wr = 0, e_bz = 0;
        logic [15:0] e_rd = 0, e_cmd = 0;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mc = 0; txn = 0; free = 0; last = 1; pd = 0;
                {e_a0, e_a1, e_er, e_wr, e_bz} = '0;
                e_rd = 16'h0; e_cmd = 16'h0;
            end else begin
                {e_a0, e_a1, e_er, e_wr} = '0;
                r = bus.spi_done && !pd;
                if (txn && mc > iss && (r || mc == iss + TMO)) begin
                    e_rd = r ? bus.spi_rd_data : 16'h0;
                    e_a0 = !id; e_a1 = id; e_er = !r;
                    last = id; txn = 0; free = mc + 1 + GAP;
                end else if (!txn && mc >= free && (bus.req0 || bus.req1)) begin
                    id = (bus.req0 && bus.req1) ? !last : bus.req1;
                    e_cmd = id ? bus.cmd1 : bus.cmd0;
                    e_wr = 1; txn = 1; iss = mc + 1;
                end
                pd = bus.spi_done;
                e_bz = txn || (mc + 1 < free);
                mc++;
            end
        end

        int  nc = 0, ne = 0;
        wr_t wq[$];
        always @(negedge clk) begin
            nc += 7;
            ne += bad($sformatf("u%0d.ack0", g), bus.ack0, e_a0);
            ne += bad($sformatf("u%0d.ack1", g), bus.ack1, e_a1);
            ne += bad($sformatf("u%0d.err", g), bus.err, e_er);
            ne += bad($sformatf("u%0d.busy", g), bus.busy, e_bz);
            ne += bad($sformatf("u%0d.spi_wrt", g), bus.spi_wrt, e_wr);
            ne += bad($sformatf("u%0d.rd_data", g), bus.rd_data, e_rd);
            ne += bad($sformatf("u%0d.spi_cmd", g), bus.spi_cmd, e_cmd);
            if (bus.spi_wrt) wq.push_back('{cyc, bus.spi_cmd});
        end
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        errors += bad(n, a, e);
    endtask

    task automatic wait_ack(input int g, input int lim, output int c, output bit id,
                            output logic [15:0] rd, output bit e);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (ack0_w[g] || ack1_w[g]) break;
        end
        if (k == lim) chk("ack_wait_expired", 0, 1);
        c = cyc; id = ack1_w[g]; rd = rd_w[g]; e = err_w[g];
    endtask

    task automatic wait_wrt(input int g, input int lim, output int c);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (wrt_w[g]) break;
        end
        if (k == lim) chk("wrt_wait_expired", 0, 1);
        c = cyc;
    endtask

    task automatic wait_idle(input int g, input int lim, output int c);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (!busy_w[g]) break;
        end
        if (k == lim) chk("idle_wait_expired", 0, 1);
        c = cyc;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (req0_t[g]) begin
                    if (ack0_w[g] ? $urandom_range(0, 3) != 0 : $urandom_range(0, 299) == 0) req0_t[g] = 0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req0_t[g] = 1; cmd0_t[g] = 16'($urandom);
                end
                if (req1_t[g]) begin
                    if (ack1_w[g] ? $urandom_range(0, 3) != 0 : $urandom_range(0, 299) == 0) req1_t[g] = 0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req1_t[g] = 1; cmd1_t[g] = 16'($urandom);
                end
            end
        end
    endtask

    initial begin
        int n, c, c2, w, nb;
        bit id, e;
        logic [15:0] rd;
        for (int g = 0; g < 2; g++) begin
            req0_t[g] = 0; req1_t[g] = 0; cmd0_t[g] = 0; cmd1_t[g] = 0;
            xfer_t[g] = 40; hang_t[g] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_wrt", wrt_w[0], 0);
        chk("rst_ack", {ack0_w[0], ack1_w[0], err_w[0]}, 0);
        chk("rst_rd_cmd", {rd_w[0], scmd_w[0]}, 0);
        rst_n = 1;

        // single client, loopback master, real transfer length
        @(negedge clk);
        nb = u[0].wq.size(); n = cyc;
        xfer_t[0] = 560; cmd0_t[0] = 16'hA5C3; req0_t[0] = 1;
        wait_ack(0, 2000, c, id, rd, e);
        req0_t[0] = 0;
        chk("single_wrt_count", u[0].wq.size() - nb, 1);
        chk("single_wrt_cycle", u[0].wq[nb].c, n + 1);
        chk("single_ack_cycle", c, u[0].rise + 1);
        chk("single_rd", rd, 16'hA5C3);
        chk("single_id_err", {id, e}, 0);
        wait_idle(0, 50, c);

        // tie after reset: 1111, 2222, 1111 with fixed spacing
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        nb = u[0].wq.size();
        xfer_t[0] = 40;
        cmd0_t[0] = 16'h1111; cmd1_t[0] = 16'h2222; req0_t[0] = 1; req1_t[0] = 1;
        wait_ack(0, 200, c, id, rd, e);
        chk("tie_ack1_id", id, 0);
        wait_ack(0, 200, c, id, rd, e);
        chk("tie_ack2_id", id, 1);
        chk("tie_ack2_rd", rd, 16'h2222);
        wait_ack(0, 200, c, id, rd, e);
        req0_t[0] = 0; req1_t[0] = 0;
        chk("tie_ack3_id", id, 0);
        chk("tie_cmd0", u[0].wq[nb].d, 16'h1111);
        chk("tie_cmd1", u[0].wq[nb + 1].d, 16'h2222);
        chk("tie_cmd2", u[0].wq[nb + 2].d, 16'h1111);
        chk("tie_space1", u[0].wq[nb + 1].c - u[0].wq[nb].c, 40 + 8 + 2);
        chk("tie_space2", u[0].wq[nb + 2].c - u[0].wq[nb + 1].c, 40 + 8 + 2);
        wait_idle(0, 50, c);

        // done still high from previous transfer: only the late rise completes
        nb = u[0].wq.size();
        xfer_t[0] = 560; cmd1_t[0] = 16'h3C3C; req1_t[0] = 1;
        wait_ack(0, 2000, c, id, rd, e);
        req1_t[0] = 0;
        chk("sticky_latency", c - u[0].wq[nb].c, 561);
        chk("sticky_rd", rd, 16'h3C3C);
        chk("sticky_id_err", {id, e}, 2'b10);
        wait_idle(0, 50, c);

        // watchdog abort
        nb = u[0].wq.size();
        hang_t[0] = 1; cmd1_t[0] = 16'h0BAD; req1_t[0] = 1;
        wait_ack(0, 1200, c, id, rd, e);
        req1_t[0] = 0;
        chk("tmo_latency", c - u[0].wq[nb].c, 1025);
        chk("tmo_id_err", {id, e}, 2'b11);
        chk("tmo_rd", rd, 16'h0000);
        wait_idle(0, 50, c2);
        chk("tmo_gap_len", c2 - c, 8);
        hang_t[0] = 0;

        // reset during WAIT, after client 0 was served last
        xfer_t[0] = 40; cmd0_t[0] = 16'h7777; req0_t[0] = 1;
        wait_ack(0, 200, c, id, rd, e);
        req0_t[0] = 0;
        wait_idle(0, 50, c);
        req0_t[0] = 1;
        wait_wrt(0, 50, w);
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rstw_busy", busy_w[0], 0);
        chk("rstw_ack", {ack0_w[0], ack1_w[0], err_w[0], wrt_w[0]}, 0);
        chk("rstw_rd_cmd", {rd_w[0], scmd_w[0]}, 0);
        req0_t[0] = 0;
        @(negedge clk);
        rst_n = 1;
        cmd0_t[0] = 16'h4444; cmd1_t[0] = 16'h5555; req0_t[0] = 1; req1_t[0] = 1;
        nb = u[0].wq.size();
        wait_wrt(0, 50, w);
        chk("rstw_tie_cmd", scmd_w[0], 16'h4444);
        wait_ack(0, 200, c, id, rd, e);
        req0_t[0] = 0; req1_t[0] = 0;
        chk("rstw_ack_id", id, 0);
        wait_idle(0, 50, c);

        // GAP_CYC = 0: held request re-issues two cycles after the done edge
        xfer_t[1] = 30; cmd0_t[1] = 16'h6666; req0_t[1] = 1;
        wait_ack(1, 200, c, id, rd, e);
        chk("b2b_ack_edge", c, u[1].rise + 1);
        wait_wrt(1, 20, w);
        chk("b2b_wrt_after_edge", w - u[1].rise, 2);
        req0_t[1] = 0;
        wait_ack(1, 200, c, id, rd, e);
        chk("b2b_dropped_req_ack", {id, e, rd}, {2'b00, 16'h6666});
        wait_idle(1, 50, c);

        rnd_en = 1;
        rand_phase(30000);
        for (int g = 0; g < 2; g++) begin
            req0_t[g] = 0; req1_t[g] = 0;
        end
        wait_idle(0, 3000, c);
        wait_idle(1, 3000, c);
        repeat (5) @(negedge clk);

        checks += u[0].nc + u[1].nc;
        errors += u[0].ne + u[1].ne;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_arb2.md
# spi_arb2

Two-client arbiter and sequencer for the shared 16-bit SPI master in the Segway sensor path. It lets two independent requesters share one master instance, for example the inertial-sensor interface and the A2D/steer-pot interface. It accepts level-held transaction requests, grants them round-robin, and drives the master's `wrt`/`cmd`. It then waits for the master's `done`, returns the 16-bit read data and a one-cycle acknowledge to the granted client, and enforces a minimum SS_n-high gap between transactions. A watchdog aborts the wait if `done` never rises.

## Interface
- `GAP_CYC`, default 8: idle clocks inserted after each transaction before the next grant; 0 means no gap.
- `TIMEOUT`, default 1024: clocks allowed in WAIT before abort; must be at least 600, since one transfer takes about 560 clocks.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0` in 1: client 0 request, held high until `ack0`.
- `cmd0` in 16: client 0 command word, held stable while `req0` is high.
- `req1` in 1: client 1 request, same rules as client 0.
- `cmd1` in 16: client 1 command word.
- `ack0` out 1: one-cycle pulse; the client 0 transaction is finished.
- `ack1` out 1: one-cycle pulse; the client 1 transaction is finished.
- `rd_data` out 16: read word for the acked client; valid while `ack0`/`ack1` is high and held until the next ack.
- `err` out 1: pulses together with `ack0`/`ack1` when the transaction timed out.
- `busy` out 1: high in every state except IDLE.
- `spi_wrt` out 1: to master `wrt`; one-cycle pulse.
- `spi_cmd` out 16: to master `cmd`; valid in the `spi_wrt` cycle and held afterwards.
- `spi_done` in 1: from master `done`; level signal that stays high until the next `wrt`.
- `spi_rd_data` in 16: from master `rd_data`.

## Operation
- States:
  - IDLE: wait for a request.
  - ISSUE: drive the write pulse.
  - WAIT: wait for the master to finish.
  - GAP: hold off before the next grant.
- All outputs are registered. Reset values: `ack0`/`ack1`/`err`/`spi_wrt`/`busy` = 0; `rd_data`/`spi_cmd` = 16'h0000; state = IDLE; last-grant = 1, so client 0 wins first.
- IDLE:
  - Exactly one request high: that client is granted.
  - Both requests high: the client not served last is granted (strict alternation).
  - On grant: `spi_cmd` <= the granted `cmd`, record the granted id, go to ISSUE.
- ISSUE: `spi_wrt` is high for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Keep a registered `done_q` copy of `spi_done`.
  - Because `done` is sticky, completion is the rising edge only: `spi_done & ~done_q`. A `done` still high from the previous transaction is ignored.
  - On the edge: `rd_data` <= `spi_rd_data`, pulse the granted client's ack, set last-grant = granted id, go to GAP.
  - When the timeout counter reaches TIMEOUT-1 with no edge: `rd_data` <= 16'h0000, pulse ack plus `err`, go to GAP.
  - The master itself is not aborted.
- GAP:
  - Count GAP_CYC clocks, then go to IDLE.
  - With GAP_CYC = 0, go directly from the completion edge to IDLE.
- Requests seen during ISSUE/WAIT/GAP are not lost, because requesters hold them. They are evaluated only in IDLE.
- A client that drops `req` before its ack: the transaction still completes and the ack is still issued.
- Counter widths:
  - Timeout counter: `$clog2(TIMEOUT)` bits.
  - Gap counter: `$clog2(GAP_CYC+1)` bits, minimum 1.
  - Both saturate; neither wraps.
- Asynchronous reset mid-transaction returns everything to reset values immediately. No ack is issued for the interrupted transaction.

## Timing
- Request at cycle N (state IDLE) → `spi_wrt` = 1 and `spi_cmd` valid at N+1.
- Master `done` rises at cycle D → ack/`rd_data` valid at D+1, for exactly one cycle.
- Next grant is evaluated at D+1+GAP_CYC; the earliest next `spi_wrt` is at D+2+GAP_CYC.
- Timeout: ack + `err` at ISSUE+1+TIMEOUT.
- `busy` rises at N+1 and falls when the state returns to IDLE.
- `ack0` and `ack1` are never high together.
- `spi_wrt` is never high outside ISSUE.

## Test plan
- **Single client, real master:** `req0`, `cmd0` = 16'hA5C3, loopback MISO=MOSI model.
  - One `spi_wrt` pulse, at N+1.
  - `ack0` at done-edge+1 with `rd_data` = 16'hA5C3, `err` = 0.
- **Simultaneous requests after reset:** `req0` = `req1` = 1 with `cmd0` = 16'h1111, `cmd1` = 16'h2222.
  - Order of `spi_cmd` values: 16'h1111, then 16'h2222, then 16'h1111 (alternating while both are held).
  - Spacing between consecutive `spi_wrt` pulses is at least transfer time + GAP_CYC + 2.
- **Sticky done:**
  - Stimulus: `spi_done` held high from the previous transfer; master model lowers it 1 cycle after `wrt` and raises it 560 cycles later.
  - Exactly one ack, at the late rise; none immediately after ISSUE.
- **Timeout:** master model never raises `done`, TIMEOUT = 1024.
  - `ack1` + `err` at ISSUE+1025 with `rd_data` = 0.
  - Then a GAP of GAP_CYC cycles, then IDLE.
- **Reset mid-WAIT:** assert `rst_n` = 0 during WAIT.
  - All outputs go to 0 immediately; no ack is issued.
  - After release, client 0 wins a tie.
- **GAP_CYC = 0 back-to-back:** a single client re-requests.
  - The next `spi_wrt` arrives exactly 2 cycles after the done edge.
